hazard_fwd_tracker: RTL and testbench

Parametrised forwarding and hazard unit for the decode/issue point of the RISC-V pipeline. It tracks the destination registers of the last DEPTH issued instructions in an internal shift register. For each source operand of the instruction in decode it selects the youngest in-flight producer to forward from. When that producer's data is not yet available (load latency), it raises a stall. It generalises the fixed one-/two-cycle forwarding selects to any depth, any number of source operands and a configurable load latency.

---
 rtl/hazard_fwd_tracker.sv | 76 +++++++
 tb/tb_hazard_fwd_tracker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_tracker.sv
// hazard_fwd_tracker: youngest-producer forwarding select and load-use stall over DEPTH in-flight slots.
// Optional statistics counters are enabled by defining HAZ_STATS_EN; otherwise they read as 0.
module hazard_fwd_tracker #(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int RA_W     = 5,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [RA_W-1:0]          issue_rd,
  input  logic                     issue_wen,
  input  logic                     issue_is_load,
  input  logic [NUM_SRC*RA_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [31:0]              stall_count,
  output logic [31:0]              fwd_count
);
  localparam int CW = LOAD_LAT > 0 ? $clog2(LOAD_LAT + 1) : 1;
  logic [DEPTH-1:0] vld;
  logic [RA_W-1:0]  rd  [DEPTH];
  logic [CW-1:0]    cnt [DEPTH];
  logic [NUM_SRC-1:0] req;
  logic accept;
  // per-operand lookup: scan oldest to youngest so the youngest match wins
  always_comb begin
    req = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = DEPTH - 1; k >= 0; k--)
        if (src_used[i] && src_addr[i*RA_W +: RA_W] != '0 && vld[k] && rd[k] == src_addr[i*RA_W +: RA_W]) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          req[i] = cnt[k] != '0;
        end
  end
  assign stall  = issue_valid && |req && !flush;
  assign accept = issue_valid && !stall && !flush && issue_wen && issue_rd != '0;
  // shift the producer slots every cycle; stalls and rejected issues enter as bubbles
  always_ff @(posedge clk) begin
    vld <= (!rst_n || flush) ? '0 : (vld << 1) | DEPTH'(accept);
    rd[0] <= issue_rd;
    cnt[0] <= issue_is_load ? CW'(LOAD_LAT) : '0;
    for (int k = 1; k < DEPTH; k++) begin
      rd[k] <= rd[k-1];
      cnt[k] <= cnt[k-1] == '0 ? '0 : cnt[k-1] - 1'b1;
    end
  end
`ifdef HAZ_STATS_EN
  logic [31:0] n_fwd;
  logic [32:0] fsum;
  always_comb begin
    n_fwd = '0;
    for (int i = 0; i < NUM_SRC; i++)
      n_fwd += 32'(fwd_sel[i*SEL_W +: SEL_W] != '0);
  end
  assign fsum = {1'b0, fwd_count} + {1'b0, n_fwd};
  // saturating stall and forward counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
      fwd_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (!stall) fwd_count <= fsum[32] ? '1 : fsum[31:0];
    end
  end
`else
  assign stall_count = '0;
  assign fwd_count = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_tracker.sv
// tb_hazard_fwd_tracker: directed checks of forwarding selects, load-use stalls, flush and reset.
module tb_hazard_fwd_tracker;
`ifdef HAZ_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  logic clk = 0, rst_n = 0;
  logic issue_valid, issue_wen, issue_is_load, flush;
  logic [4:0] issue_rd;
  logic [9:0] src_addr;
  logic [1:0] src_used;
  logic stall, stall_z;
  logic [3:0] fwd_sel, sel_z;
  logic [31:0] stall_count, fwd_count, sc_z, fc_z;
  int n = 0, fails = 0;

  hazard_fwd_tracker #(.NUM_SRC(2), .DEPTH(3), .LOAD_LAT(1), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
    .issue_is_load(issue_is_load), .src_addr(src_addr), .src_used(src_used), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .stall_count(stall_count), .fwd_count(fwd_count));

  hazard_fwd_tracker #(.NUM_SRC(2), .DEPTH(3), .LOAD_LAT(0), .RA_W(5)) dut_z (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
    .issue_is_load(issue_is_load), .src_addr(src_addr), .src_used(src_used), .flush(flush),
    .stall(stall_z), .fwd_sel(sel_z), .stall_count(sc_z), .fwd_count(fc_z));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wen = 0; issue_is_load = 0; issue_rd = 0;
    src_addr = 0; src_used = 0; flush = 0;
  endtask

  task automatic produce(input logic [4:0] r, input logic ld);
    idle();
    issue_valid = 1; issue_wen = 1; issue_rd = r; issue_is_load = ld;
  endtask

  task automatic consume(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] u);
    idle();
    issue_valid = 1; src_addr = {a1, a0}; src_used = u;
  endtask

  task automatic settle();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    consume(5'd1, 5'd2, 2'b11);
    #2;
    n++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    n++; if (fwd_sel !== 4'h0) begin fails++; $display("FAIL reset_sel: got %0h expected 0", fwd_sel); end
    n++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall_count: got %0d expected 0", stall_count); end
    n++; if (fwd_count !== 32'd0) begin fails++; $display("FAIL reset_fwd_count: got %0d expected 0", fwd_count); end
    settle();
  endtask

  task automatic test_alu_fwd();
    produce(5'd5, 1'b0);
    tick();
    consume(5'd5, 5'd0, 2'b01);
    #2;
    n++; if (fwd_sel[1:0] !== 2'd1) begin fails++; $display("FAIL alu_sel_age1: got %0d expected 1", fwd_sel[1:0]); end
    n++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_stall: got %0b expected 0", stall); end
    tick();
    #2;
    n++; if (fwd_sel[1:0] !== 2'd2) begin fails++; $display("FAIL alu_sel_age2: got %0d expected 2", fwd_sel[1:0]); end
    tick();
    #2;
    n++; if (fwd_sel[1:0] !== 2'd3) begin fails++; $display("FAIL alu_sel_age3: got %0d expected 3", fwd_sel[1:0]); end
    tick();
    #2;
    n++; if (fwd_sel[1:0] !== 2'd0) begin fails++; $display("FAIL alu_sel_age4: got %0d expected 0", fwd_sel[1:0]); end
    n++; if (sel_z[1:0] !== 2'd0) begin fails++; $display("FAIL alu_z_sel_age4: got %0d expected 0", sel_z[1:0]); end
    settle();
  endtask

  task automatic test_load_use();
    produce(5'd7, 1'b1);
    tick();
    consume(5'd0, 5'd7, 2'b10);
    #2;
    n++; if (stall !== 1'b1) begin fails++; $display("FAIL load_stall: got %0b expected 1", stall); end
    n++; if (fwd_sel[3:2] !== 2'd1) begin fails++; $display("FAIL load_sel_while_stall: got %0d expected 1", fwd_sel[3:2]); end
    n++; if (stall_z !== 1'b0) begin fails++; $display("FAIL load_lat0_stall: got %0b expected 0", stall_z); end
    n++; if (sel_z[3:2] !== 2'd1) begin fails++; $display("FAIL load_lat0_sel: got %0d expected 1", sel_z[3:2]); end
    tick();
    #2;
    n++; if (stall !== 1'b0) begin fails++; $display("FAIL load_stall_release: got %0b expected 0", stall); end
    n++; if (fwd_sel[3:2] !== 2'd2) begin fails++; $display("FAIL load_sel_after: got %0d expected 2", fwd_sel[3:2]); end
    settle();
  endtask

  task automatic test_youngest();
    produce(5'd9, 1'b0);
    tick();
    produce(5'd9, 1'b0);
    tick();
    consume(5'd9, 5'd9, 2'b11);
    #2;
    n++; if (fwd_sel !== 4'b0101) begin fails++; $display("FAIL youngest_both: got %0h expected 5", fwd_sel); end
    settle();
    produce(5'd9, 1'b0);
    tick();
    produce(5'd9, 1'b1);
    tick();
    consume(5'd9, 5'd0, 2'b01);
    #2;
    n++; if (stall !== 1'b1) begin fails++; $display("FAIL youngest_load_stall: got %0b expected 1", stall); end
    n++; if (fwd_sel[1:0] !== 2'd1) begin fails++; $display("FAIL youngest_load_sel: got %0d expected 1", fwd_sel[1:0]); end
    tick();
    #2;
    n++; if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2) begin fails++; $display("FAIL youngest_after: got stall %0b sel %0d expected 0 2", stall, fwd_sel[1:0]); end
    settle();
  endtask

  task automatic test_x0_unused();
    produce(5'd0, 1'b1);
    tick();
    consume(5'd0, 5'd0, 2'b11);
    #2;
    n++; if (fwd_sel !== 4'h0 || stall !== 1'b0) begin fails++; $display("FAIL x0: got sel %0h stall %0b expected 0 0", fwd_sel, stall); end
    produce(5'd6, 1'b0);
    tick();
    consume(5'd6, 5'd0, 2'b00);
    #2;
    n++; if (fwd_sel !== 4'h0) begin fails++; $display("FAIL unused_sel: got %0h expected 0", fwd_sel); end
    tick();
    consume(5'd6, 5'd0, 2'b01);
    #2;
    n++; if (fwd_sel[1:0] !== 2'd2) begin fails++; $display("FAIL used_sel: got %0d expected 2", fwd_sel[1:0]); end
    settle();
  endtask

  task automatic test_flush();
    produce(5'd3, 1'b1);
    tick();
    consume(5'd3, 5'd0, 2'b01);
    issue_wen = 1; issue_rd = 5'd3; flush = 1;
    #2;
    n++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %0b expected 0", stall); end
    tick();
    consume(5'd3, 5'd0, 2'b01);
    #2;
    n++; if (fwd_sel !== 4'h0) begin fails++; $display("FAIL flush_sel_after: got %0h expected 0", fwd_sel); end
    n++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall_after: got %0b expected 0", stall); end
    settle();
  endtask

  task automatic test_reset_mid_stall();
    produce(5'd1, 1'b0);
    tick();
    produce(5'd2, 1'b0);
    tick();
    produce(5'd4, 1'b1);
    tick();
    consume(5'd4, 5'd1, 2'b11);
    #2;
    n++; if (stall !== 1'b1) begin fails++; $display("FAIL mid_stall_before: got %0b expected 1", stall); end
    rst_n = 0;
    tick();
    rst_n = 1;
    consume(5'd1, 5'd4, 2'b11);
    #2;
    n++; if (stall !== 1'b0 || fwd_sel !== 4'h0) begin fails++; $display("FAIL mid_reset_out: got stall %0b sel %0h expected 0 0", stall, fwd_sel); end
    n++; if (stall_count !== 32'd0 || fwd_count !== 32'd0) begin fails++; $display("FAIL mid_reset_counts: got %0d %0d expected 0 0", stall_count, fwd_count); end
    tick();
    produce(5'd8, 1'b1);
    tick();
    consume(5'd8, 5'd0, 2'b01);
    #2;
    n++; if (stall !== 1'b1) begin fails++; $display("FAIL post_reset_stall: got %0b expected 1", stall); end
    tick();
    #2;
    n++; if (stall_count !== 32'(STATS)) begin fails++; $display("FAIL stall_count_first: got %0d expected %0d", stall_count, STATS); end
    n++; if (fwd_count !== 32'd0) begin fails++; $display("FAIL fwd_count_none: got %0d expected 0", fwd_count); end
    n++; if (fwd_sel[1:0] !== 2'd2 || stall !== 1'b0) begin fails++; $display("FAIL post_reset_sel: got %0d stall %0b expected 2 0", fwd_sel[1:0], stall); end
    tick();
    #2;
    n++; if (fwd_count !== 32'(STATS)) begin fails++; $display("FAIL fwd_count_first: got %0d expected %0d", fwd_count, STATS); end
    settle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_youngest();
    test_x0_unused();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
